// File: rtl/anc_pkg.sv
// Shared types and arithmetic for the anti-noise output path.
//   SAMPLE_W   : audio sample width
//   sample_t   : signed audio sample
//   SAMPLE_MAX / SAMPLE_MIN : clamp limits
//   sat_sub()  : a - b, clamped to the sample_t range
package anc_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // One guard bit is enough for a 16-bit difference: overflow shows up as the
    // guard bit disagreeing with the sample sign bit.
    function automatic sample_t sat_sub(input sample_t a, input sample_t b);
        logic [SAMPLE_W:0] diff;
        diff = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
        if (diff[SAMPLE_W] != diff[SAMPLE_W-1]) begin
            return diff[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
        end
        return sample_t'(diff[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/anc_output_mixer_pwm_dac.sv
// First-order PWM DAC for a signed sample.
//   clk_in    : system clock
//   reset_in  : synchronous active-high reset
//   sample_in : signed sample; converted to offset binary for the duty
//   pwm_out   : registered PWM drive, high while counter < duty
// Period is 2^PWM_BITS cycles (PWM_BITS legal range 4..12). The duty register
// only reloads on the counter wrap so a period in flight is never glitched.
module pwm_dac
    import anc_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic    clk_in,
    input  logic    reset_in,
    input  sample_t sample_in,
    output logic    pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [SAMPLE_W-1:0] offset;
    logic [PWM_BITS-1:0] duty_src;
    logic                pwm_q;

    // Flipping the sign bit maps -32768..32767 onto 0..65535.
    assign offset   = sample_in ^ 16'h8000;
    assign duty_src = offset[SAMPLE_W-1 -: PWM_BITS];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt_q  <= '0;
            duty_q <= DUTY_MID;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
                duty_q <= duty_src;
            end
            pwm_q <= (cnt_q < duty_q);
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/anc_output_mixer.sv
// Anti-noise output mixer: pairs each anti-noise sample with the current
// playback sample, drives speaker = music - anti (saturated), and feeds the
// result to a PWM DAC.
//   clk_in / reset_in     : clock, synchronous active-high reset
//   music_in / music_ready_in : playback sample + one-cycle valid strobe
//   anti_in / anti_ready_in   : anti-noise sample + one-cycle valid strobe
//   mix_out / mix_valid_out   : saturated mix + one-cycle update strobe
//   pwm_out               : PWM DAC drive for the speaker pin
//   overrun_count_out     : saturating count of held samples overwritten unpaired
module anc_output_mixer
    import anc_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned OVR_W    = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic signed [SAMPLE_W-1:0] music_in,
    input  logic                       music_ready_in,
    input  logic signed [SAMPLE_W-1:0] anti_in,
    input  logic                       anti_ready_in,
    output logic signed [SAMPLE_W-1:0] mix_out,
    output logic                       mix_valid_out,
    output logic                       pwm_out,
    output logic [OVR_W-1:0]           overrun_count_out
);

    sample_t          music_hold_q, music_hold_d;
    sample_t          anti_hold_q, anti_hold_d;
    logic             music_full_q, music_full_d;
    logic             anti_full_q, anti_full_d;
    sample_t          mix_q, mix_d;
    logic             mix_valid_q, mix_valid_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;

    sample_t music_val;
    sample_t anti_val;
    logic    fire;
    logic    overrun;

    // A fresh strobe beats the held value.
    assign music_val = music_ready_in ? music_in : music_hold_q;
    assign anti_val  = anti_ready_in ? anti_in : anti_hold_q;
    assign fire      = (music_full_q | music_ready_in) & (anti_full_q | anti_ready_in);
    // At most one slot can overrun per cycle: a full slot being refilled while
    // the other is full or strobing would have fired instead.
    assign overrun   = ~fire & ((music_ready_in & music_full_q) |
                                (anti_ready_in & anti_full_q));

    always_comb begin
        music_hold_d = music_hold_q;
        anti_hold_d  = anti_hold_q;
        music_full_d = music_full_q;
        anti_full_d  = anti_full_q;
        mix_d        = mix_q;
        mix_valid_d  = 1'b0;
        ovr_d        = ovr_q;

        if (fire) begin
            mix_d        = sat_sub(music_val, anti_val);
            mix_valid_d  = 1'b1;
            music_full_d = 1'b0;
            anti_full_d  = 1'b0;
        end else begin
            if (music_ready_in) begin
                music_hold_d = music_in;
                music_full_d = 1'b1;
            end
            if (anti_ready_in) begin
                anti_hold_d = anti_in;
                anti_full_d = 1'b1;
            end
        end

        if (overrun && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            music_hold_q <= '0;
            anti_hold_q  <= '0;
            music_full_q <= 1'b0;
            anti_full_q  <= 1'b0;
            mix_q        <= '0;
            mix_valid_q  <= 1'b0;
            ovr_q        <= '0;
        end else begin
            music_hold_q <= music_hold_d;
            anti_hold_q  <= anti_hold_d;
            music_full_q <= music_full_d;
            anti_full_q  <= anti_full_d;
            mix_q        <= mix_d;
            mix_valid_q  <= mix_valid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign mix_out           = mix_q;
    assign mix_valid_out     = mix_valid_q;
    assign overrun_count_out = ovr_q;

    pwm_dac #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_dac (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .sample_in (mix_q),
        .pwm_out   (pwm_out)
    );

endmodule

// File: tb/tb_anc_output_mixer.sv
module tb_anc_output_mixer;

    logic               clk_in = 1'b0;
    logic               reset_in;
    logic signed [15:0] music_in;
    logic               music_ready_in;
    logic signed [15:0] anti_in;
    logic               anti_ready_in;
    logic signed [15:0] mix_out;
    logic               mix_valid_out;
    logic               pwm_out;
    logic [7:0]         overrun_count_out;

    int tests = 0;
    int fails = 0;

    anc_output_mixer #(
        .PWM_BITS (8),
        .OVR_W    (8)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .music_in          (music_in),
        .music_ready_in    (music_ready_in),
        .anti_in           (anti_in),
        .anti_ready_in     (anti_ready_in),
        .mix_out           (mix_out),
        .mix_valid_out     (mix_valid_out),
        .pwm_out           (pwm_out),
        .overrun_count_out (overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mix(input string tag, input int exp);
        logic [15:0] e;
        e = 16'(exp);
        tests++;
        assert (mix_out === e) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, mix_out, $signed(e));
        end
    endtask

    // Strobe the chosen streams for one cycle; outputs are then the N+1 view.
    task automatic strobe(input logic m, input int mv, input logic a, input int av);
        music_in       = 16'(mv);
        music_ready_in = m;
        anti_in        = 16'(av);
        anti_ready_in  = a;
        tick();
        music_ready_in = 1'b0;
        anti_ready_in  = 1'b0;
    endtask

    // High cycles over one full 256-cycle window.
    task automatic pwm_high(output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            cnt += int'(pwm_out);
        end
    endtask

    initial begin
        int hi;

        reset_in       = 1'b1;
        music_in       = '0;
        music_ready_in = 1'b0;
        anti_in        = '0;
        anti_ready_in  = 1'b0;
        tick();
        tick();

        // Reset state
        chk_mix("rst_mix", 0);
        chk("rst_valid", 32'(mix_valid_out), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_ovr", 32'(overrun_count_out), 0);
        reset_in = 1'b0;
        tick();
        tick();
        pwm_high(hi);
        chk("rst_pwm_mid", 32'(hi), 128);

        // Music first, anti five cycles later
        strobe(1'b1, 1000, 1'b0, 0);
        chk("mf_novalid0", 32'(mix_valid_out), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mf_novalid", 32'(mix_valid_out), 0);
        end
        strobe(1'b0, 0, 1'b1, 200);
        chk("mf_valid", 32'(mix_valid_out), 1);
        chk_mix("mf_mix", 800);
        tick();
        chk("mf_valid_once", 32'(mix_valid_out), 0);

        // Simultaneous strobes
        strobe(1'b1, -5, 1'b1, 7);
        chk("sim_valid", 32'(mix_valid_out), 1);
        chk_mix("sim_mix", -12);
        tick();
        chk("sim_valid_once", 32'(mix_valid_out), 0);

        // Anti first, then music
        strobe(1'b0, 0, 1'b1, -1);
        chk("af_novalid", 32'(mix_valid_out), 0);
        strobe(1'b1, -32768, 1'b0, 0);
        chk_mix("af_mix_neg_edge", -32767);

        // Saturation
        strobe(1'b1, 32767, 1'b1, 0);
        chk_mix("sat_edge_pos", 32767);
        strobe(1'b1, 30000, 1'b1, -10000);
        chk_mix("sat_pos", 32767);
        repeat (260) tick();
        pwm_high(hi);
        chk("pwm_duty_max", 32'(hi), 255);
        strobe(1'b1, -30000, 1'b1, 10000);
        chk_mix("sat_neg", -32768);
        repeat (260) tick();
        pwm_high(hi);
        chk("pwm_duty_zero", 32'(hi), 0);

        // Overrun
        strobe(1'b0, 0, 1'b1, 100);
        chk("ovr_zero", 32'(overrun_count_out), 0);
        strobe(1'b0, 0, 1'b1, 300);
        chk("ovr_one", 32'(overrun_count_out), 1);
        chk("ovr_novalid", 32'(mix_valid_out), 0);
        strobe(1'b1, 0, 1'b0, 0);
        chk("ovr_valid", 32'(mix_valid_out), 1);
        chk_mix("ovr_mix", -300);
        // Music slot held, then 300 overwriting strobes.
        strobe(1'b1, 5, 1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            strobe(1'b1, i, 1'b0, 0);
        end
        chk("ovr_sat", 32'(overrun_count_out), 255);
        strobe(1'b0, 0, 1'b1, 0);
        chk_mix("ovr_last_wins", 299);

        // Reset mid-operation
        strobe(1'b1, 42, 1'b0, 0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("mr_ovr_clr", 32'(overrun_count_out), 0);
        chk_mix("mr_mix_clr", 0);
        strobe(1'b0, 0, 1'b1, 1);
        chk("mr_novalid", 32'(mix_valid_out), 0);
        tick();
        chk("mr_novalid2", 32'(mix_valid_out), 0);
        strobe(1'b1, 10, 1'b0, 0);
        chk("mr_valid", 32'(mix_valid_out), 1);
        chk_mix("mr_mix", 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
